// File: rtl/fetch_stage.sv
// Instruction fetch stage: 64-word instruction memory, PC register, IF/ID
// pipeline register and a BOOT/RUN/HALT fetch controller.
module fetch_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        imem_we,
  input  logic [5:0]  imem_waddr,
  input  logic [31:0] imem_wdata,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [5:0]  op_code,
  output logic        halted,
  output logic        addr_err
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetchState_t;

  fetchState_t state;
  fetchState_t stateNext;

  logic [31:0] imem [64];

  logic [31:0] fetchWord;
  logic [31:0] pcPlus4;
  logic        redirectOk;
  logic        sentinel;

  logic [31:0] pcNext;
  logic [31:0] instrNext;
  logic [31:0] pc4Next;
  logic        validNext;
  logic        errNext;

  // Asynchronous read: the index wraps naturally because only pc[7:2] is used.
  assign fetchWord  = imem[pc[7:2]];
  assign pcPlus4    = pc + 32'd4;
  assign redirectOk = branch_taken && (branch_target[1:0] == 2'b00);
  assign sentinel   = (fetchWord == '1);

  assign op_code = if_id_instr[31:26];
  assign halted  = (state == HALT);

  // Program-load write port; deliberately untouched by rst.
  always_ff @(posedge clk) begin
    if (imem_we)
      imem[imem_waddr] <= imem_wdata;
  end

  // State, PC, IF/ID register and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT;
      pc          <= '0;
      if_id_instr <= '0;
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
      addr_err    <= 1'b0;
    end else begin
      state       <= stateNext;
      pc          <= pcNext;
      if_id_instr <= instrNext;
      if_id_pc4   <= pc4Next;
      if_id_valid <= validNext;
      addr_err    <= errNext;
    end
  end

  // Next-state and datapath selection: redirect > halt sentinel > flush > stall > normal.
  always_comb begin
    stateNext = state;
    pcNext    = pc;
    instrNext = if_id_instr;
    pc4Next   = if_id_pc4;
    validNext = if_id_valid;
    errNext   = addr_err;

    unique case (state)
      BOOT: begin
        stateNext = RUN;
        instrNext = '0;
        pc4Next   = '0;
        validNext = 1'b0;
      end

      RUN: begin
        if (branch_taken && !redirectOk)
          errNext = 1'b1;

        if (redirectOk) begin
          pcNext    = branch_target;
          instrNext = '0;
          pc4Next   = '0;
          validNext = 1'b0;
        end else if (!stall && sentinel) begin
          // Sentinel wins over flush so a flush cannot mask the halt.
          stateNext = HALT;
          instrNext = '0;
          pc4Next   = '0;
          validNext = 1'b0;
        end else if (flush) begin
          instrNext = '0;
          pc4Next   = '0;
          validNext = 1'b0;
          if (!stall)
            pcNext = pcPlus4;
        end else if (!stall) begin
          pcNext    = pcPlus4;
          instrNext = fetchWord;
          pc4Next   = pcPlus4;
          validNext = 1'b1;
        end
      end

      HALT: begin
        instrNext = '0;
        pc4Next   = '0;
        validNext = 1'b0;
      end

      default: begin
        stateNext = BOOT;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_we;
  logic [5:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic [5:0]  op_code;
  logic        halted;
  logic        addr_err;

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_we       (imem_we),
    .imem_waddr    (imem_waddr),
    .imem_wdata    (imem_wdata),
    .pc            (pc),
    .if_id_instr   (if_id_instr),
    .if_id_pc4     (if_id_pc4),
    .if_id_valid   (if_id_valid),
    .op_code       (op_code),
    .halted        (halted),
    .addr_err      (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state
  localparam int MODE_BOOT = 0;
  localparam int MODE_RUN  = 1;
  localparam int MODE_HALT = 2;

  logic [31:0] mMem [64];
  logic [31:0] mPc;
  logic [31:0] mInstr;
  logic [31:0] mPc4;
  bit          mValid;
  bit          mErr;
  int          mMode;

  int passCount = 0;
  int totalCount = 0;
  bit checkEn = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCount++;
    if (act === exp)
      passCount++;
    else
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] pattern(input int i);
    logic [5:0]  hi;
    logic [25:0] lo;
    hi = 6'(i);
    lo = 26'(i * 7 + 1);
    return {hi, lo};
  endfunction

  // Compare every cycle against the model, away from the rising edge.
  always @(negedge clk) begin
    if (checkEn) begin
      chk("pc", pc, mPc);
      chk("if_id_instr", if_id_instr, mInstr);
      chk("if_id_pc4", if_id_pc4, mPc4);
      chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, mValid});
      chk("op_code", {26'd0, op_code}, {26'd0, mInstr[31:26]});
      chk("halted", {31'd0, halted}, {31'd0, (mMode == MODE_HALT)});
      chk("addr_err", {31'd0, addr_err}, {31'd0, mErr});
    end
  end

  // One clock: drive inputs, advance the model by the fetch rules, wait for the edge.
  task automatic step(input bit r, input bit s, input bit f, input bit b,
                      input logic [31:0] t, input bit we, input logic [5:0] wa,
                      input logic [31:0] wd);
    logic [31:0] nPc, nInstr, nPc4, word;
    bit nValid, nErr, bubble;
    int nMode;
    rst = r; stall = s; flush = f; branch_taken = b; branch_target = t;
    imem_we = we; imem_waddr = wa; imem_wdata = wd;

    nPc = mPc; nInstr = mInstr; nPc4 = mPc4; nValid = mValid; nErr = mErr;
    nMode = mMode; bubble = 0;
    if (r) begin
      nPc = 0; nInstr = 0; nPc4 = 0; nValid = 0; nErr = 0; nMode = MODE_BOOT;
    end else if (mMode == MODE_BOOT) begin
      nMode = MODE_RUN; bubble = 1;
    end else if (mMode == MODE_HALT) begin
      bubble = 1;
    end else begin
      word = mMem[(mPc / 4) % 64];
      if (b && (t % 4 == 0)) begin
        nPc = t; bubble = 1;
      end else begin
        if (b) nErr = 1;
        if (!s && word == 32'hFFFF_FFFF) begin
          bubble = 1; nMode = MODE_HALT;
        end else if (f) begin
          bubble = 1;
          if (!s) nPc = mPc + 4;
        end else if (!s) begin
          nInstr = word; nPc4 = mPc + 4; nValid = 1; nPc = mPc + 4;
        end
      end
    end
    if (bubble) begin
      nInstr = 0; nPc4 = 0; nValid = 0;
    end

    @(posedge clk);
    mPc = nPc; mInstr = nInstr; mPc4 = nPc4; mValid = nValid; mErr = nErr; mMode = nMode;
    if (we) mMem[wa] = wd;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1; stall = 0; flush = 0; branch_taken = 0; branch_target = 0;
    imem_we = 0; imem_waddr = 0; imem_wdata = 0;
    mPc = 0; mInstr = 0; mPc4 = 0; mValid = 0; mErr = 0; mMode = MODE_BOOT;
    @(negedge clk);

    // Clear memory under reset, then load the scenario-1 program.
    for (int i = 0; i < 64; i++) begin
      step(1, 0, 0, 0, 0, 1, 6'(i), 32'd0);
      checkEn = 1;
    end
    step(1, 0, 0, 0, 0, 1, 6'd0, 32'h8C01_0004);
    step(1, 0, 0, 0, 0, 1, 6'd1, 32'h2022_0001);
    step(1, 0, 0, 0, 0, 1, 6'd2, 32'hFFFF_FFFF);
    chk("reset pc", pc, 32'h0);
    chk("reset valid", {31'd0, if_id_valid}, 32'd0);
    chk("reset halted", {31'd0, halted}, 32'd0);
    chk("reset addr_err", {31'd0, addr_err}, 32'd0);

    // Scenario 1: sequential fetch into halt
    idle(1);
    chk("boot pc", pc, 32'h0);
    chk("boot valid", {31'd0, if_id_valid}, 32'd0);
    idle(1);
    chk("s1 instr0", if_id_instr, 32'h8C01_0004);
    chk("s1 op0", {26'd0, op_code}, 32'h23);
    chk("s1 pc4_0", if_id_pc4, 32'd4);
    idle(1);
    chk("s1 instr1", if_id_instr, 32'h2022_0001);
    chk("s1 op1", {26'd0, op_code}, 32'h08);
    chk("s1 pc4_1", if_id_pc4, 32'd8);
    idle(1);
    chk("s1 halt valid", {31'd0, if_id_valid}, 32'd0);
    chk("s1 halted", {31'd0, halted}, 32'd1);
    chk("s1 halt pc", pc, 32'd8);
    step(0, 1, 1, 1, 32'h40, 0, 0, 0);
    chk("halt ignores redirect", pc, 32'd8);
    chk("halt stays", {31'd0, halted}, 32'd1);

    // Scenario 6: reset out of HALT, memory preserved
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("s6 pc", pc, 32'd0);
    chk("s6 halted", {31'd0, halted}, 32'd0);
    idle(2);
    chk("s6 mem kept", if_id_instr, 32'h8C01_0004);

    // Reload memory with a sentinel-free pattern
    for (int i = 0; i < 64; i++) step(1, 0, 0, 0, 0, 1, 6'(i), pattern(i));

    // Scenario 2: stall then flush
    idle(5);
    chk("s2 pc", pc, 32'h10);
    chk("s2 instr", if_id_instr, pattern(3));
    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    chk("s2 stall pc", pc, 32'h10);
    chk("s2 stall instr", if_id_instr, pattern(3));
    idle(1);
    chk("s2 resume pc", pc, 32'h14);
    chk("s2 resume instr", if_id_instr, pattern(4));
    step(0, 0, 1, 0, 0, 0, 0, 0);
    chk("s2 flush valid", {31'd0, if_id_valid}, 32'd0);
    chk("s2 flush pc", pc, 32'h18);

    // Scenario 3: redirect beats stall
    step(0, 1, 0, 1, 32'h40, 0, 0, 0);
    chk("s3 pc", pc, 32'h40);
    chk("s3 valid", {31'd0, if_id_valid}, 32'd0);
    idle(1);
    chk("s3 instr", if_id_instr, pattern(16));
    chk("s3 pc4", if_id_pc4, 32'h44);

    // Scenario 4: misaligned redirect
    step(0, 0, 0, 1, 32'h42, 0, 0, 0);
    chk("s4 pc", pc, 32'h48);
    chk("s4 err", {31'd0, addr_err}, 32'd1);
    chk("s4 instr", if_id_instr, pattern(17));
    idle(3);
    chk("s4 err sticky", {31'd0, addr_err}, 32'd1);

    // Scenario 5: memory index wrap
    step(0, 0, 0, 1, 32'hFC, 0, 0, 0);
    chk("s5 pc", pc, 32'hFC);
    idle(1);
    chk("s5 instr63", if_id_instr, pattern(63));
    chk("s5 pc100", pc, 32'h100);
    idle(1);
    chk("s5 instr0", if_id_instr, pattern(0));
    chk("s5 pc4", if_id_pc4, 32'h104);

    // 32-bit PC wrap
    step(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0);
    idle(1);
    chk("wrap pc", pc, 32'h0);
    chk("wrap pc4", if_id_pc4, 32'h0);
    chk("wrap instr", if_id_instr, pattern(63));

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      bit r, s, f, b, we;
      logic [31:0] t, wd;
      r  = ($urandom_range(0, 39) == 0);
      s  = ($urandom_range(0, 4) == 0);
      f  = ($urandom_range(0, 7) == 0);
      b  = ($urandom_range(0, 7) == 0);
      t  = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_01FC);
      if ($urandom_range(0, 3) == 0) t[1:0] = 2'($urandom_range(1, 3));
      we = ($urandom_range(0, 9) == 0);
      wd = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : $urandom;
      step(r, s, f, b, t, we, 6'($urandom_range(0, 63)), wd);
    end

    checkEn = 0;
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The port list SHALL be as follows. The clock is clk. The reset is rst: synchronous, active-high, and the only reset. The clock and reset ports SHALL be listed first.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 stall  input  1  hold PC and IF/ID register.
REQ-005 flush  input  1  replace IF/ID contents with a bubble.
REQ-006 branch_taken  input  1  redirect PC to branch_target (resolved downstream from branch & ALU result).
REQ-007 branch_target  input  32  byte address of the redirect.
REQ-008 imem_we  input  1  instruction-memory write enable (program load).
REQ-009 imem_waddr  input  6  word index to write.
REQ-010 imem_wdata  input  32  word to write.
REQ-011 pc  output  32  current fetch address.
REQ-012 if_id_instr  output  32  registered instruction.
REQ-013 if_id_pc4  output  32  registered PC+4 of that instruction.
REQ-014 if_id_valid  output  1  IF/ID holds a real instruction.
REQ-015 op_code  output  6  if_id_instr[31:26], combinational; feeds unidad_de_control.
REQ-016 halted  output  1  fetch FSM is in HALT.
REQ-017 addr_err  output  1  sticky misaligned-redirect flag.

Function
REQ-018 Instruction memory SHALL be 64x32 words, indexed by pc[7:2]. The read SHALL be combinational. The write SHALL be synchronous on imem_we. A same-cycle read and write to the same index SHALL return the old word.
REQ-019 Fetch latency SHALL be 1 cycle: the word at pc appears on if_id_instr at the next edge if not stalled, flushed or redirected.
REQ-020 The FSM SHALL have three states: BOOT, RUN and HALT.
REQ-021 BOOT SHALL last exactly 1 cycle after rst deasserts, with pc held at 0 and if_id_valid=0. The FSM SHALL then enter RUN.
REQ-022 RUN, normal cycle: pc <= pc+4 (32-bit wrap, 0xFFFFFFFC -> 0). IF/ID SHALL load {mem[pc[7:2]], pc+4, valid=1}.
REQ-023 Memory index wrap SHALL be implicit: pc=0x100 reads word 0.
REQ-024 RUN priority SHALL be, highest first: branch_taken, then flush, then stall, then normal.
REQ-025 branch_taken=1 with branch_target[1:0]==0 SHALL set pc <= branch_target and load a bubble into IF/ID, regardless of stall.
REQ-026 branch_taken=1 with branch_target[1:0]!=0 SHALL be ignored as a redirect, SHALL set addr_err=1, and the cycle SHALL proceed by flush/stall/normal rules.
REQ-027 flush=1 without a redirect SHALL load a bubble into IF/ID; pc SHALL advance unless stall=1.
REQ-028 stall=1 alone SHALL hold pc and all IF/ID fields.
REQ-029 A bubble SHALL be if_id_instr=0, if_id_pc4=0, if_id_valid=0. This gives op_code=000000, an R-type sll $0 NOP.
REQ-030 Halt sentinel: in RUN, with no redirect and no stall, if mem[pc[7:2]]==0xFFFFFFFF, IF/ID SHALL load a bubble, pc SHALL hold, and the FSM SHALL enter HALT.
REQ-031 If flush=1 in the same cycle as a halt sentinel, the FSM SHALL still enter HALT.
REQ-032 HALT SHALL hold pc, keep IF/ID as a bubble and ignore stall, flush and branch_taken. Imem writes SHALL still be accepted. HALT SHALL be exited only by rst.
REQ-033 halted SHALL be 1 exactly while in HALT.
REQ-034 addr_err SHALL remain 1 until rst.

Reset
REQ-035 When rst=1 at a rising edge, the block SHALL set pc=0, if_id_instr=0, if_id_pc4=0, if_id_valid=0, halted=0, addr_err=0 and state=BOOT.
REQ-036 Reset SHALL override all other inputs, including mid-stall, mid-redirect and HALT.
REQ-037 Instruction memory contents SHALL NOT be affected by rst. An imem write in a reset cycle SHALL still be performed.

Verification
REQ-038 Scenario 1 (sequential fetch): load mem[0..2]=0x8C010004 (lw), 0x20220001 (addi), 0xFFFFFFFF; release rst. Required response: BOOT 1 cycle; if_id_instr 0x8C010004 (op_code 100011, pc4=4), then 0x20220001 (op_code 001000, pc4=8), then a bubble with halted=1 and pc=8.
REQ-039 Scenario 2 (stall then flush): assert stall 2 cycles during RUN at pc=0x10. Required response: pc and IF/ID frozen, then resume with pc=0x14. Then assert flush 1 cycle: if_id_valid=0 while pc advances.
REQ-040 Scenario 3 (redirect beats stall): branch_taken=1, branch_target=0x40, stall=1 in the same cycle. Required response: next pc=0x40, if_id_valid=0; following cycle if_id_instr=mem[16].
REQ-041 Scenario 4 (misaligned redirect): branch_target=0x42 with branch_taken=1. Required response: pc advances by 4, addr_err=1 stays set until rst.
REQ-042 Scenario 5 (wrap-around): redirect to 0xFC with no sentinel in memory. Required response: next instruction comes from mem[63]; pc=0x100 reads mem[0] with pc4=0x104.
REQ-043 Scenario 6 (reset mid-HALT): pulse rst while in HALT. Required response: all outputs return to reset values and memory contents are unchanged.
